// File: rtl/hz_pkg.sv
// ---------------------------------------------------------------------------
// hz_pkg
// Shared definitions for the pipeline hazard / forwarding controller:
//   - forwarding select codes driven onto the 3:1 operand muxes
//   - Tuse / Tnew encodings used by the decoder
//   - tracking entry type {we, wa, tnew}
//   - match, stall and select helper functions (youngest stage first)
// ---------------------------------------------------------------------------
package hz_pkg;

  localparam int HZ_AW = 5;
  localparam int HZ_TW = 2;

  // Forwarding select codes. 2'b11 is never produced.
  localparam logic [1:0] FWD_SRC  = 2'b00;
  localparam logic [1:0] FWD_NEAR = 2'b01;
  localparam logic [1:0] FWD_FAR  = 2'b10;

  // Cycles until the operand is consumed (from D).
  localparam logic [HZ_TW-1:0] TUSE_D    = 2'd0;
  localparam logic [HZ_TW-1:0] TUSE_E    = 2'd1;
  localparam logic [HZ_TW-1:0] TUSE_NONE = 2'd3;

  // Cycles after entering E until the result sits at a stage output.
  localparam logic [HZ_TW-1:0] TNEW_JAL  = 2'd0;
  localparam logic [HZ_TW-1:0] TNEW_ALU  = 2'd1;
  localparam logic [HZ_TW-1:0] TNEW_LOAD = 2'd2;

  typedef struct packed {
    logic             we;
    logic [HZ_AW-1:0] wa;
    logic [HZ_TW-1:0] tnew;
  } entry_t;

  localparam entry_t ENTRY_CLR = '0;

  // Saturating decrement applied each time an entry advances a stage.
  function automatic logic [HZ_TW-1:0] tnew_dec(input logic [HZ_TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Register 0 is hard-wired, so it never matches an in-flight write.
  function automatic logic hit(input entry_t e, input logic [HZ_AW-1:0] r);
    return e.we && (e.wa == r) && (r != '0);
  endfunction

  // The nearest producer decides: an E match shadows any older M match.
  function automatic logic src_stall(input entry_t e, input entry_t m,
                                     input logic [HZ_AW-1:0] r,
                                     input logic [HZ_TW-1:0] tuse);
    logic s;
    s = 1'b0;
    if (tuse != TUSE_NONE) begin
      if (hit(e, r))      s = (e.tnew > tuse);
      else if (hit(m, r)) s = (m.tnew > tuse);
    end
    return s;
  endfunction

  function automatic logic [1:0] fwd_sel_d(input entry_t e, input entry_t m,
                                           input logic [HZ_AW-1:0] r);
    logic [1:0] sel;
    sel = FWD_SRC;
    if (hit(e, r)) begin
      if (e.tnew == '0) sel = FWD_NEAR;
    end else if (hit(m, r) && (m.tnew == '0)) begin
      sel = FWD_FAR;
    end
    return sel;
  endfunction

  function automatic logic [1:0] fwd_sel_e(input entry_t m, input entry_t w,
                                           input logic [HZ_AW-1:0] r);
    logic [1:0] sel;
    sel = FWD_SRC;
    if (hit(m, r)) begin
      if (m.tnew == '0) sel = FWD_NEAR;
    end else if (hit(w, r)) begin
      sel = FWD_FAR;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hz_entry_reg.sv
// ---------------------------------------------------------------------------
// hz_entry_reg
// One in-flight destination-write tracking entry {we, wa, tnew}.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears the entry)
//   bubble_i    - load an empty entry instead of ent_i
//   dec_i       - saturating-decrement tnew while capturing ent_i
//   ent_i       - entry arriving from the previous stage
//   ent_o       - registered entry
// ---------------------------------------------------------------------------
module hz_entry_reg
  import hz_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   bubble_i,
  input  logic   dec_i,
  input  entry_t ent_i,
  output entry_t ent_o
);

  entry_t ent_q, ent_d;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ent_d = ent_i;
    if (dec_i)    ent_d.tnew = tnew_dec(ent_i.tnew);
    if (bubble_i) ent_d = ENTRY_CLR;
  end

  // NOTE: state uses non-blocking assignment so all stages advance off the
  // same pre-edge values; reset is synchronous and clears every field.
  always_ff @(posedge clk) begin
    if (reset) ent_q <= ENTRY_CLR;
    else       ent_q <= ent_d;
  end

  assign ent_o = ent_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
// Stall and forwarding-select generator for the five-stage MIPS pipeline.
// Tracks register writes in flight through E, M and W.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   d_valid, d_rs, d_rt        - D-stage instruction and its sources
//   d_tuse_rs, d_tuse_rt       - cycles until each source is consumed
//   d_we, d_wa, d_tnew         - D-stage destination write description
//   stall                      - freeze PC and IF/D, bubble into E
//   fwd_rs_d, fwd_rt_d         - D-stage compare-operand selects
//   fwd_rs_e, fwd_rt_e         - E-stage ALU-operand selects
//   stall_cnt                  - stall cycle counter (HZ_STALL_CNT_EN only)
// Optional feature macro: HZ_STALL_CNT_EN.
// AW/TW must match the widths used by hz_pkg::entry_t.
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl
  import hz_pkg::*;
#(
  parameter int AW = HZ_AW,
  parameter int TW = HZ_TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_we,
  input  logic [AW-1:0] d_wa,
  input  logic [TW-1:0] d_tnew,
  output logic          stall,
  output logic [1:0]    fwd_rs_d,
  output logic [1:0]    fwd_rt_d,
  output logic [1:0]    fwd_rs_e,
  output logic [1:0]    fwd_rt_e
`ifdef HZ_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  entry_t d_ent, e_ent, m_ent, w_ent;
  logic [AW-1:0] e_rs_q, e_rt_q, e_rs_d, e_rt_d;

  // An invalid D slot enters E as a non-writing instruction.
  always_comb begin
    d_ent      = ENTRY_CLR;
    d_ent.we   = d_we & d_valid;
    d_ent.wa   = d_wa;
    d_ent.tnew = d_tnew;
  end

  always_comb begin
    stall = d_valid & (src_stall(e_ent, m_ent, d_rs, d_tuse_rs) |
                       src_stall(e_ent, m_ent, d_rt, d_tuse_rt));
  end

  // E captures D as-is (tnew counts from entering E); M and W age by one.
  hz_entry_reg u_e_ent (
    .clk     (clk),
    .reset   (reset),
    .bubble_i(stall),
    .dec_i   (1'b0),
    .ent_i   (d_ent),
    .ent_o   (e_ent)
  );

  hz_entry_reg u_m_ent (
    .clk     (clk),
    .reset   (reset),
    .bubble_i(1'b0),
    .dec_i   (1'b1),
    .ent_i   (e_ent),
    .ent_o   (m_ent)
  );

  hz_entry_reg u_w_ent (
    .clk     (clk),
    .reset   (reset),
    .bubble_i(1'b0),
    .dec_i   (1'b1),
    .ent_i   (m_ent),
    .ent_o   (w_ent)
  );

  // Source addresses of the E instruction, needed only for E-stage selects;
  // they follow the E entry, including the bubble on stall.
  always_comb begin
    e_rs_d = d_rs;
    e_rt_d = d_rt;
    if (stall) begin
      e_rs_d = '0;
      e_rt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q <= '0;
      e_rt_q <= '0;
    end else begin
      e_rs_q <= e_rs_d;
      e_rt_q <= e_rt_d;
    end
  end

  // W write-through for D reads is done inside the register file.
  always_comb begin
    fwd_rs_d = fwd_sel_d(e_ent, m_ent, d_rs);
    fwd_rt_d = fwd_sel_d(e_ent, m_ent, d_rt);
    fwd_rs_e = fwd_sel_e(m_ent, w_ent, e_rs_q);
    fwd_rt_e = fwd_sel_e(m_ent, w_ent, e_rt_q);
  end

`ifdef HZ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running count; wraps naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard controller for the five-stage MIPS core. It tracks destination-register writes in flight through E, M and W, and generates the 2-bit forwarding select codes that drive the 32-bit 3:1 operand muxes at D and E. It also raises the D-stage stall when a needed result cannot be forwarded in time. It sits beside the D/E pipeline registers and is the only producer of forwarding selects in the datapath.

## Interface
Parameters:
- AW, 5, register address width
- TW, 2, width of Tuse/Tnew fields

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high; clears all tracking state
- d_valid  in  1  D stage holds a real instruction
- d_rs, d_rt  in  AW each  source register addresses in D
- d_tuse_rs, d_tuse_rt  in  TW each  cycles until operand consumed (0 = used in D, 1 = used in E, 3 = not read)
- d_we  in  1  D instruction writes a register
- d_wa  in  AW  destination address in D
- d_tnew  in  TW  cycles after entering E until result is at a stage output (jal 0, ALU 1, load 2)
- stall  out  1  freeze PC and IF/D register; insert bubble into E
- fwd_rs_d, fwd_rt_d  out  2 each  D-stage compare-operand selects: 00 register file, 01 E-stage value, 10 M-stage value
- fwd_rs_e, fwd_rt_e  out  2 each  E-stage ALU-operand selects: 00 D/E pipeline value, 01 M-stage value, 10 W-stage value
- stall_cnt  out  32  stall cycle count (only with HZ_STALL_CNT_EN)

## Operation
- Internal entries E, M, W, each holding {we, wa, tnew}. The E entry also holds the rs/rt addresses.
- Every cycle, M→W and E→M advance. tnew decrements on each advance and saturates at 0.
- D→E when stall=0: the D fields are captured with we = d_we & d_valid.
- When stall=1: E is loaded with a bubble (we=0, wa=0, rs=rt=0).
- Writes to register 0 are ignored: any entry with wa==0 matches nothing.
- Match rule for source r in a stage: entry.we && entry.wa==r && r!=0.
- Stall fires when d_valid and, for rs or rt with tuse≠3, the nearest matching entry among E and M has tnew > tuse. stall is combinational from the D inputs and the current entries.
- D selects:
  - nearest match in E with tnew==0 → 01
  - else a match in M with tnew==0 → 10
  - else 00
  - The register file handles W write-through internally.
- E selects, using the E entry's rs/rt:
  - match in M with tnew==0 → 01
  - else a match in W → 10
  - else 00
- Priority is always the youngest stage first. Code 11 is never produced.

## Timing
- Reset: all entries cleared (we=0, wa=0, tnew=0); stall=0; all selects 00; stall_cnt=0.
- Reset asserted mid-stream clears entries on that edge. Outputs are 00/0 on the following cycle, regardless of d_* inputs, until new entries load.
- Select outputs are combinational, valid in the same cycle as the consumer mux.
- A load followed by a dependent ALU op (tuse 1) gives exactly 1 stall cycle.
- A load followed by a dependent branch (tuse 0) gives 2 stall cycles.
- An ALU op followed by a branch (tuse 0) gives 1 stall cycle.
- A repeated stall re-evaluates each cycle as entries advance. There is no internal state machine beyond the entry pipeline.
- When d_valid=0, stall=0.

## Configuration
- HZ_STALL_CNT_EN defined:
  - stall_cnt increments by 1 on every clk edge where stall=1 and reset=0.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset.
- HZ_STALL_CNT_EN undefined: no stall_cnt port and no counter logic; behaviour is otherwise identical.

## Structure
- Shared package hz_pkg holds:
  - select codes FWD_SRC=2'b00, FWD_NEAR=2'b01, FWD_FAR=2'b10
  - TUSE_D=0, TUSE_E=1, TUSE_NONE=3
  - TNEW_JAL=0, TNEW_ALU=1, TNEW_LOAD=2
  - entry typedef {we, wa, tnew}
- One sub-module, hz_entry_reg: a single tracking entry with load, bubble, saturating-decrement and reset.
- Instantiated three times. Only E uses the extra rs/rt fields.

## Test plan
- Reset then idle: reset=1 for 2 cycles, then d_valid=0 → stall=0, all selects 00, stall_cnt=0.
- ALU→ALU: addu $3 (tnew 1), then subu using $3 as rs (tuse 1) → no stall; next cycle fwd_rs_e=01.
- lw→ALU: lw $5 (tnew 2), then addu reading $5 as rt with tuse 1 → stall=1 for one cycle; then fwd_rt_e=10.
- lw→beq: lw $5, then beq $5 with tuse 0 → stall 2 cycles; then fwd_rs_d=00, with register-file write-through.
- Register 0 and priority:
  - write $0, then read $0 → no stall, selects 00.
  - two back-to-back writes to $7, then a read of $7 → fwd_rs_e=01 (the youngest write wins).
- Reset mid-stall and counter: during an lw→beq stall assert reset → next cycle stall=0 and stall_cnt=0. Without reset, the stall count after the lw→beq sequence is 2.
